// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory bus between instruction fetch and data access,
// serving at most one of each per pipeline advance (data first) with a per-transaction watchdog.
module mem_port_arbiter #(
    parameter int TO_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        im_req,
    input  logic [31:0] im_addr,
    output logic [31:0] im_rdata,
    input  logic        dm_req,
    input  logic [3:0]  dm_web,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        PCstall_axi,
    output logic        DMstall_axi,
    output logic        bus_req,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic        bus_timeout
);

    typedef enum logic [1:0] {IDLE, DM, IM} state_t;

    // The counter holds the number of cycles already waited, so the transaction is forced
    // to complete in the cycle where that count would reach all-ones (2^TO_W-1 cycles total).
    localparam logic [TO_W-1:0] WD_LAST = {TO_W{1'b1}} - 1'b1;

    state_t          state_reg;
    logic            im_done_reg;
    logic            dm_done_reg;
    logic [TO_W-1:0] wd_reg;

    logic need_im, need_dm, advance, busy, expire, complete;
    logic unused_addr_bits;

    assign need_im     = im_req & ~im_done_reg;
    assign need_dm     = dm_req & ~dm_done_reg;
    assign PCstall_axi = need_im;
    assign DMstall_axi = need_dm;
    assign advance     = ~need_im & ~need_dm;
    assign busy        = (state_reg != IDLE);
    assign expire      = busy & ~bus_ready & (wd_reg == WD_LAST);
    assign complete    = busy & (bus_ready | expire);

    assign unused_addr_bits = ^{im_addr[1:0], dm_addr[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            im_done_reg <= 1'b0;
            dm_done_reg <= 1'b0;
            wd_reg      <= '0;
            bus_req     <= 1'b0;
            bus_write   <= 1'b0;
            bus_addr    <= '0;
            bus_wstrb   <= '0;
            bus_wdata   <= '0;
            im_rdata    <= '0;
            dm_rdata    <= '0;
            bus_timeout <= 1'b0;
        end else begin
            if (advance) begin
                im_done_reg <= 1'b0;
                dm_done_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (need_dm) begin
                        state_reg <= DM;
                        bus_req   <= 1'b1;
                        bus_write <= |dm_web;
                        bus_addr  <= {dm_addr[31:2], 2'b00};
                        bus_wstrb <= dm_web;
                        bus_wdata <= dm_wdata;
                        wd_reg    <= '0;
                    end else if (need_im) begin
                        state_reg <= IM;
                        bus_req   <= 1'b1;
                        bus_write <= 1'b0;
                        bus_addr  <= {im_addr[31:2], 2'b00};
                        bus_wstrb <= 4'b0000;
                        bus_wdata <= '0;
                        wd_reg    <= '0;
                    end
                end
                DM: begin
                    if (complete) begin
                        state_reg <= IDLE;
                        bus_req   <= 1'b0;
                        // A request withdrawn mid-transaction leaves no trace on the CPU side.
                        if (dm_req) begin
                            dm_done_reg <= 1'b1;
                            dm_rdata    <= (bus_write || expire) ? 32'h0 : bus_rdata;
                        end
                    end else begin
                        wd_reg <= wd_reg + 1'b1;
                    end
                end
                IM: begin
                    if (complete) begin
                        state_reg <= IDLE;
                        bus_req   <= 1'b0;
                        if (im_req) begin
                            im_done_reg <= 1'b1;
                            im_rdata    <= expire ? 32'h0 : bus_rdata;
                        end
                    end else begin
                        wd_reg <= wd_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            if (expire) begin
                bus_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench: a scripted bus responder plus a per-advance reference model of
// transaction order, stall release cycles, returned data and the sticky timeout flag.
module tb_mem_port_arbiter;

    localparam int TO_W   = 4;
    localparam int TO_CYC = (1 << TO_W) - 1;

    logic        clk, rst;
    logic        im_req, dm_req;
    logic [31:0] im_addr, im_rdata, dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_web;
    logic        PCstall_axi, DMstall_axi;
    logic        bus_req, bus_write, bus_ready, bus_timeout;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;

    mem_port_arbiter #(.TO_W(TO_W)) dut (
        .clk(clk), .rst(rst),
        .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata),
        .dm_req(dm_req), .dm_web(dm_web), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata),
        .PCstall_axi(PCstall_axi), .DMstall_axi(DMstall_axi),
        .bus_req(bus_req), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_timeout(bus_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Responder script (one entry per transaction) and observed transactions.
    int          wait_q[$];
    logic [31:0] data_q[$];
    logic [68:0] obs_q[$];

    // Reference model state
    logic [31:0] exp_im, exp_dm;
    bit          exp_tmo;

    initial begin
        bit          in_txn;
        int          cnt, cur_wait;
        logic [31:0] cur_data;
        logic [68:0] cap;
        in_txn    = 1'b0;
        cnt       = 0;
        cur_wait  = 0;
        cur_data  = '0;
        cap       = '0;
        bus_ready = 1'b0;
        bus_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!bus_req) begin
                in_txn    = 1'b0;
                bus_ready = 1'($urandom_range(0, 1));
                bus_rdata = $urandom;
            end else begin
                if (!in_txn) begin
                    in_txn   = 1'b1;
                    cnt      = 0;
                    cap      = {bus_write, bus_wstrb, bus_addr, bus_wdata};
                    obs_q.push_back(cap);
                    cur_wait = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
                    cur_data = (data_q.size() > 0) ? data_q.pop_front() : $urandom;
                end else begin
                    check("bus_addr_stable", 64'(bus_addr), 64'(cap[63:32]));
                    check("bus_ctl_stable", 64'({bus_write, bus_wstrb, bus_wdata}),
                          64'({cap[68:64], cap[31:0]}));
                end
                if (cnt == cur_wait) begin
                    bus_ready = 1'b1;
                    bus_rdata = cur_data;
                end else begin
                    bus_ready = 1'b0;
                    bus_rdata = $urandom;
                end
                cnt++;
            end
        end
    end

    task automatic plan(input bit dm_on, input int dw, input int iw,
                        input logic [31:0] dres, input logic [31:0] ires);
        if (dm_on) begin
            wait_q.push_back(dw);
            data_q.push_back(dres);
        end
        wait_q.push_back(iw);
        data_q.push_back(ires);
    endtask

    function automatic int dur(input int w);
        return (w >= TO_CYC) ? TO_CYC : w + 1;
    endfunction

    // Runs one advance period from cycle 0 and checks it against the model.
    task automatic finish_op(input bit dm_on, input logic [3:0] web, input logic [31:0] daddr,
                             input logic [31:0] ddata, input logic [31:0] iaddr,
                             input int dw, input int iw,
                             input logic [31:0] dres, input logic [31:0] ires, input bit perturb);
        int          dfall, pfall, exp_dfall, exp_pfall;
        bit          seen;
        logic [68:0] t;
        dfall = -1;
        pfall = -1;
        seen  = 1'b0;
        exp_dfall = dm_on ? 1 + dur(dw) : 0;
        exp_pfall = exp_dfall + 1 + dur(iw);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!DMstall_axi && dfall < 0) dfall = c;
            if (!PCstall_axi && pfall < 0) pfall = c;
            if (perturb && c == 3) im_addr = $urandom;
            if (!DMstall_axi && !PCstall_axi) begin
                seen = 1'b1;
                break;
            end
        end
        check("advance_seen", 64'(seen), 64'(1));
        check("dm_stall_fall", 64'(dfall), 64'(exp_dfall));
        check("pc_stall_fall", 64'(pfall), 64'(exp_pfall));

        exp_im = (iw >= TO_CYC) ? 32'h0 : ires;
        if (dm_on) exp_dm = (web != 4'b0000 || dw >= TO_CYC) ? 32'h0 : dres;
        if ((dm_on && dw >= TO_CYC) || iw >= TO_CYC) exp_tmo = 1'b1;
        check("im_rdata", 64'(im_rdata), 64'(exp_im));
        check("dm_rdata", 64'(dm_rdata), 64'(exp_dm));
        check("bus_timeout", 64'(bus_timeout), 64'(exp_tmo));

        check("txn_count", 64'(obs_q.size()), dm_on ? 64'(2) : 64'(1));
        if (dm_on && obs_q.size() > 0) begin
            t = obs_q.pop_front();
            check("dm_bus_addr", 64'(t[63:32]), 64'({daddr[31:2], 2'b00}));
            check("dm_bus_ctl", 64'({t[68:64], t[31:0]}), 64'({(web != 4'b0000), web, ddata}));
        end
        if (obs_q.size() > 0) begin
            t = obs_q.pop_front();
            check("im_bus_addr", 64'(t[63:32]), 64'({iaddr[31:2], 2'b00}));
            check("im_bus_ctl", 64'(t[68:64]), 64'(0));
        end
        obs_q.delete();
        $display("op dm=%0d web=%b daddr=%h iaddr=%h dw=%0d iw=%0d dfall=%0d pfall=%0d",
                 dm_on, web, daddr, iaddr, dw, iw, dfall, pfall);
    endtask

    task automatic drive(input bit dm_on, input logic [3:0] web, input logic [31:0] daddr,
                         input logic [31:0] ddata, input logic [31:0] iaddr, input bit release_rst);
        @(posedge clk);
        #2;
        if (release_rst) rst = 1'b1;
        im_req   = 1'b1;
        im_addr  = iaddr;
        dm_req   = dm_on;
        dm_web   = web;
        dm_addr  = daddr;
        dm_wdata = ddata;
    endtask

    task automatic do_op(input bit dm_on, input logic [3:0] web, input logic [31:0] daddr,
                         input logic [31:0] ddata, input logic [31:0] iaddr,
                         input int dw, input int iw, input logic [31:0] dres,
                         input logic [31:0] ires, input bit perturb, input bit release_rst);
        plan(dm_on, dw, iw, dres, ires);
        drive(dm_on, web, daddr, ddata, iaddr, release_rst);
        finish_op(dm_on, web, daddr, ddata, iaddr, dw, iw, dres, ires, perturb);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bus_req"}, 64'(bus_req), 64'(0));
        check({tag, "_bus_fields"}, 64'({bus_write, bus_wstrb, bus_addr, bus_wdata}), 64'(0));
        check({tag, "_rdata"}, {im_rdata, dm_rdata}, 64'(0));
        check({tag, "_timeout"}, 64'(bus_timeout), 64'(0));
        check({tag, "_stalls"}, 64'({PCstall_axi, DMstall_axi}), 64'({im_req, dm_req}));
    endtask

    initial begin
        logic [3:0]  web;
        logic [31:0] dres;
        bit          dm_on;
        exp_im   = '0;
        exp_dm   = '0;
        exp_tmo  = 1'b0;
        rst      = 1'b1;
        im_req   = 1'b1;
        dm_req   = 1'b0;
        im_addr  = '0;
        dm_web   = '0;
        dm_addr  = '0;
        dm_wdata = '0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Fetch only, released straight out of reset
        do_op(1'b0, 4'b0000, 32'h0, 32'h0, 32'h0000_0104, 0, 0, 32'h0, 32'h0000_0013, 1'b0, 1'b1);
        // Load plus fetch, zero wait
        do_op(1'b1, 4'b0000, 32'h2004, 32'h0, 32'h108, 0, 0, 32'hCAFE_F00D, 32'h0000_0093, 1'b0, 1'b0);
        // Unaligned store
        do_op(1'b1, 4'b1100, 32'h2002, 32'hABCD_0000, 32'h10C, 0, 0, 32'h1234_5678, 32'h0000_0113, 1'b0, 1'b0);
        // Fetch with 5 wait states and a perturbed address mid-wait
        do_op(1'b0, 4'b0000, 32'h0, 32'h0, 32'h110, 0, 5, 32'h0, 32'h0040_0513, 1'b1, 1'b0);
        // Load that never gets bus_ready
        do_op(1'b1, 4'b0000, 32'h3000, 32'h0, 32'h114, 99, 0, 32'hDEAD_BEEF, 32'h0000_0593, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            dm_on = 1'($urandom_range(0, 1));
            web   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
            dres  = $urandom;
            do_op(dm_on, web, $urandom, $urandom, $urandom,
                  $urandom_range(0, 4), $urandom_range(0, 4), dres, $urandom, 1'b0, 1'b0);
        end

        // Reset while a load is on the bus
        plan(1'b1, 3, 0, 32'h5555_AAAA, 32'h0000_0013);
        drive(1'b1, 4'b0000, 32'h4008, 32'h0, 32'h200, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("bus_req_before_rst", 64'(bus_req), 64'(1));
        rst = 1'b0;
        #1;
        exp_im  = '0;
        exp_dm  = '0;
        exp_tmo = 1'b0;
        check_reset_outputs("mid_reset");
        repeat (2) @(posedge clk);
        #2;
        wait_q.delete();
        data_q.delete();
        obs_q.delete();
        plan(1'b1, 1, 2, 32'h5555_AAAA, 32'h0000_0013);
        drive(1'b1, 4'b0000, 32'h4008, 32'h0, 32'h200, 1'b1);
        finish_op(1'b1, 4'b0000, 32'h4008, 32'h0, 32'h200, 1, 2, 32'h5555_AAAA, 32'h0000_0013, 1'b0);

        do_op(1'b1, 4'b0011, 32'h4010, 32'h0000_BEEF, 32'h204, 2, 1, 32'h0, 32'h0000_0033, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port memory bus between the CPU's instruction fetch and its data access, and turns the outstanding work into the CPU's `PCstall_axi`/`DMstall_axi` pipeline-freeze inputs. It sits between the CPU core and the bus master wrapper. Each pipeline advance it serves at most one data access and one fetch, data first, then releases both stalls together. A watchdog bounds every bus transaction.

## Interface
- `TO_W`, 8: width of the per-transaction watchdog counter. A timeout fires after 2^TO_W−1 cycles without `bus_ready`.
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `im_req`  in  1  fetch request; tied high by the CPU outside reset
- `im_addr`  in  32  fetch address (CPU `face_pc`)
- `im_rdata`  out  32  registered fetch data (CPU `face_inst`)
- `dm_req`  in  1  data access request (CPU `face_DMOn`)
- `dm_web`  in  4  byte write enables (CPU `face_MemRW`); 4'b0000 = read
- `dm_addr`  in  32  data address (CPU `face_ALUOut`)
- `dm_wdata`  in  32  store data (CPU `face_Wdata`)
- `dm_rdata`  out  32  registered load data (CPU `face_Rdata`)
- `PCstall_axi`  out  1  fetch not yet served
- `DMstall_axi`  out  1  data access not yet served
- `bus_req`  out  1  transaction valid
- `bus_write`  out  1  1 = write
- `bus_addr`  out  32  word-aligned address
- `bus_wstrb`  out  4  byte strobes; 0 on reads
- `bus_wdata`  out  32  write data
- `bus_ready`  in  1  transaction complete this cycle; `bus_rdata` is valid
- `bus_rdata`  in  32  read data
- `bus_timeout`  out  1  sticky: a transaction timed out since reset

## Operation
- Internal flags `im_done` and `dm_done`:
  - `need_im = im_req & ~im_done`, `need_dm = dm_req & ~dm_done`.
  - `PCstall_axi = need_im`, `DMstall_axi = need_dm` (combinational).
- Advance: a cycle with both stalls low. At that edge, clear `im_done` and `dm_done`.
- FSM states IDLE, DM, IM:
  - IDLE: if `need_dm` → DM; else if `need_im` → IM; else stay.
  - DM/IM: `bus_req = 1`. On `bus_ready` or watchdog expiry: set the matching done flag, load the matching rdata register, go to IDLE.
- Priority: data over fetch, fixed. There is no starvation, because each source is served at most once per advance.
- Request capture at IDLE→DM/IM:
  - Latch `bus_addr = {addr[31:2],2'b00}`.
  - DM: `bus_write = |dm_web`, `bus_wstrb = dm_web`, `bus_wdata = dm_wdata`.
  - IM: read with `bus_wstrb = 0`.
  - Bus outputs hold these latched values for the whole transaction, whatever the CPU inputs do.
- CPU contract: request inputs stay stable while the matching stall is high.
  - If `im_req`/`dm_req` drops mid-transaction, the transaction still completes on the bus.
  - The result is discarded: no rdata load, no done flag set.
- Watchdog:
  - Counter clears on entry to DM/IM and increments each cycle in DM/IM without `bus_ready`.
  - At all-ones it completes the access as if `bus_ready` had arrived, with data 0, and sets `bus_timeout`.
  - `bus_timeout` clears only on reset.
- Writes load 0 into `dm_rdata`.

## Timing
- Reset values (asynchronous, while `rst` = 0):
  - State IDLE; both flags 0; watchdog 0.
  - `bus_req` 0, `bus_write` 0, `bus_addr` 0, `bus_wstrb` 0, `bus_wdata` 0.
  - `im_rdata` 0, `dm_rdata` 0, `bus_timeout` 0.
  - Stalls follow the requests: high whenever the matching request is high.
- Reset asserted mid-transaction: `bus_req` drops immediately and the transaction is abandoned. The bus wrapper must tolerate this.
- Fetch only, `bus_ready` in the first `bus_req` cycle:
  - Cycle 0 IDLE, cycle 1 IM with `bus_ready`.
  - Cycle 2: `im_rdata` valid, `PCstall_axi` low, advance.
  - Minimum 3 cycles per instruction.
- Fetch plus data, zero wait states:
  - DM in cycle 1, IDLE cycle 2, IM cycle 3.
  - `DMstall_axi` low from cycle 2, `PCstall_axi` low from cycle 4.
- Each bus wait state adds one cycle.
- `bus_ready` is ignored in IDLE.

## Test plan
- **Fetch only.** `im_addr` = 0x0000_0104, `bus_ready` on the first `bus_req` cycle with `bus_rdata` = 0x0000_0013 → `bus_addr` = 0x104 and `bus_write` = 0; `PCstall_axi` high in cycles 0–1 and low in cycle 2; `im_rdata` = 0x13.
- **Load plus fetch.** `dm_addr` = 0x2004 read, `im_addr` = 0x108, zero wait → first transaction at 0x2004, second at 0x108; `DMstall_axi` falls at cycle 2 and `PCstall_axi` at cycle 4; both done flags clear after the advance.
- **Unaligned store.** `dm_web` = 4'b1100, `dm_addr` = 0x2002, `dm_wdata` = 0xABCD_0000 → `bus_addr` = 0x2000, `bus_write` = 1, `bus_wstrb` = 1100, `bus_wdata` = 0xABCD_0000; `dm_rdata` = 0.
- **Wait states.** `bus_ready` delayed 5 cycles on a fetch → bus outputs stable for all 6 cycles even when `im_addr` is perturbed mid-wait; `PCstall_axi` falls 1 cycle after `bus_ready`.
- **Timeout.** `TO_W` = 4, `bus_ready` never asserted on a load → completes after 15 cycles in DM; `dm_rdata` = 0, `bus_timeout` = 1 and stays 1 across later accesses until reset.
- **Reset mid-access.** Drive `rst` low during DM → `bus_req` = 0 in the same cycle, all outputs at reset values; after release, a pending `dm_req` restarts from IDLE.
